uart_tx_buffered: RTL and testbench

//   Serial UART transmitter directly downstream of the hex-to-ASCII stage in the PDU.

---
 rtl/uart_defs_pkg.sv | 17 +
 rtl/uart_tx_buffered_fifo.sv | 67 ++++++
 rtl/uart_tx_buffered.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// UART shared definitions: FSM states and line constants.
// Reused by the buffered transmitter and the future receiver.
package uart_defs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 868;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO, first-word-fall-through read port.
// A push while full is accepted only if a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serial framer.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit before stop).
module uart_tx_buffered
  import uart_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TC  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE = 1;

  uart_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic          pop;
  logic          tc;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (tx_data_valid),
    .data_i  (tx_data),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tc = (baud_q == BAUD_TC);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_ONE;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rdata;
          state_d = START;
        end
      end
      START: begin
        if (tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tc) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tc) begin
          baud_d = '0;
          // Back-to-back frames: reload straight into START, no idle bit.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_rdata;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line level is registered from the current state, one cycle behind it.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[bit_q];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^shreg_q;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  assign ovf_d = ovf_q | (tx_data_valid & fifo_full & ~pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign overflow = ovf_q;
  assign tx_busy  = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: two instances (depth 16 and 4),
// serial monitors decode frames mid-bit and check against queued bytes.
module tb_uart_tx_buffered;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * C;
`else
  localparam int FRAME = 10 * C;
`endif

  typedef struct {
    logic [7:0] d;
    logic       p;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst16, rst4;
  logic [7:0] d16, d4;
  logic       v16, v4;
  logic       tx16, tx4;
  logic       busy16, busy4;
  logic [4:0] cnt16;
  logic [2:0] cnt4;
  logic       ovf16, ovf4;

  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;
  exp_t q16[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(16)) dut16 (
    .clk           (clk),
    .rst           (rst16),
    .tx_data       (d16),
    .tx_data_valid (v16),
    .tx            (tx16),
    .tx_busy       (busy16),
    .fifo_count    (cnt16),
    .overflow      (ovf16)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut4 (
    .clk           (clk),
    .rst           (rst4),
    .tx_data       (d4),
    .tx_data_valid (v4),
    .tx            (tx4),
    .tx_busy       (busy4),
    .fifo_count    (cnt4),
    .overflow      (ovf4)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic line(input int k);
    return (k == 4) ? tx4 : tx16;
  endfunction

  function automatic logic rline(input int k);
    return (k == 4) ? rst4 : rst16;
  endfunction

  task automatic waitn(input int k, input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (rline(k) !== 1'b1) ab = 1'b1;
    end
  endtask

  task automatic mon(input int k);
    logic [7:0] b;
    logic s0, s1, p, ab;
    int t0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (line(k) === 1'b0) begin
        t0 = cyc;
        ab = (rline(k) !== 1'b1);
        p  = 1'b0;
        waitn(k, 1, ab);
        s0 = line(k);
        for (int j = 0; j < 8; j++) begin
          waitn(k, C, ab);
          b[j] = line(k);
        end
`ifdef UART_TX_PARITY_EN
        waitn(k, C, ab);
        p = line(k);
`endif
        waitn(k, C, ab);
        s1 = line(k);
        if (!ab) begin
          if ((k == 4 ? q4.size() : q16.size()) == 0) begin
            chk($sformatf("unexpected frame dut%0d", k), {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            e = (k == 4) ? q4.pop_front() : q16.pop_front();
            chk($sformatf("start bit dut%0d", k), {31'd0, s0}, 32'd0);
            chk($sformatf("data dut%0d", k), {24'd0, b}, {24'd0, e.d});
            chk($sformatf("stop bit dut%0d", k), {31'd0, s1}, 32'd1);
`ifdef UART_TX_PARITY_EN
            chk($sformatf("parity dut%0d", k), {31'd0, p}, {31'd0, e.p});
`endif
            if (e.t >= 0)
              chk($sformatf("start time dut%0d", k), t0, e.t);
          end
        end
      end
    end
  endtask

  initial mon(16);
  initial mon(4);

  task automatic push(input int k, input logic [7:0] d, input int t);
    exp_t e;
    e.d = d;
    e.p = ^d;
    e.t = t;
    if (k == 4) q4.push_back(e);
    else q16.push_back(e);
  endtask

  task automatic put(input int k, input logic [7:0] d);
    @(negedge clk);
    if (k == 4) begin d4 = d; v4 = 1'b1; end
    else begin d16 = d; v16 = 1'b1; end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    if (k == 4) v4 = 1'b0;
    else v16 = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while ((k == 4 ? q4.size() : q16.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain dut%0d", k), k == 4 ? q4.size() : q16.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  int n0;

  initial begin
    rst16 = 1'b0; rst4 = 1'b0;
    v16 = 1'b0; v4 = 1'b0;
    d16 = '0; d4 = '0;
    repeat (3) @(negedge clk);
    chk("rst tx16", {31'd0, tx16}, 32'd1);
    chk("rst busy16", {31'd0, busy16}, 32'd0);
    chk("rst cnt16", {27'd0, cnt16}, 32'd0);
    chk("rst ovf16", {31'd0, ovf16}, 32'd0);
    chk("rst tx4", {31'd0, tx4}, 32'd1);
    chk("rst busy4", {31'd0, busy4}, 32'd0);
    chk("rst cnt4", {29'd0, cnt4}, 32'd0);
    chk("rst ovf4", {31'd0, ovf4}, 32'd0);
    rst16 = 1'b1; rst4 = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte: start bit visible two edges after the write.
    put(16, 8'h41);
    n0 = cyc + 1;
    push(16, 8'h41, n0 + 2);
    idle(16);
    chk("busy after write", {31'd0, busy16}, 32'd1);
    drain(16);
    chk("idle busy16", {31'd0, busy16}, 32'd0);

    // Eight back-to-back frames with no gap.
    for (int i = 0; i < 8; i++) begin
      put(16, 8'h31 + 8'(i));
      if (i == 0) n0 = cyc + 1;
      push(16, 8'h31 + 8'(i), n0 + 2 + i * FRAME);
    end
    idle(16);
    drain(16);
    chk("burst ovf16", {31'd0, ovf16}, 32'd0);

    // Depth-4 overflow: 0..4 kept, 5..7 dropped.
    for (int i = 0; i < 8; i++) begin
      put(4, 8'(i));
      if (i == 0) n0 = cyc + 1;
      if (i <= 4) push(4, 8'(i), n0 + 2 + i * FRAME);
    end
    idle(4);
    chk("full cnt4", {29'd0, cnt4}, 32'd4);
    chk("ovf4 set", {31'd0, ovf4}, 32'd1);

    // Write on the same edge STOP pops while full: accepted.
    while (cyc < n0 + FRAME) @(negedge clk);
    chk("cnt4 before pop", {29'd0, cnt4}, 32'd4);
    d4 = 8'hA5; v4 = 1'b1;
    push(4, 8'hA5, n0 + 2 + 5 * FRAME);
    @(negedge clk);
    v4 = 1'b0;
    chk("cnt4 full+pop", {29'd0, cnt4}, 32'd4);
    drain(4);
    chk("ovf4 sticky", {31'd0, ovf4}, 32'd1);

    // Reset mid-frame during data bit 3 of 0x55 with 3 bytes queued.
    put(16, 8'h55);
    n0 = cyc + 1;
    put(16, 8'h11);
    put(16, 8'h22);
    put(16, 8'h33);
    idle(16);
    while (cyc < n0 + 19) @(negedge clk);
    chk("queued before rst", {27'd0, cnt16}, 32'd3);
    rst16 = 1'b0;
    #1;
    chk("midrst tx16", {31'd0, tx16}, 32'd1);
    chk("midrst cnt16", {27'd0, cnt16}, 32'd0);
    chk("midrst busy16", {31'd0, busy16}, 32'd0);
    repeat (3) @(negedge clk);
    rst16 = 1'b1;
    repeat (100) @(negedge clk);
    chk("post-rst tx16", {31'd0, tx16}, 32'd1);
    chk("post-rst busy16", {31'd0, busy16}, 32'd0);

`ifdef UART_TX_PARITY_EN
    put(16, 8'h31);
    n0 = cyc + 1;
    q16.push_back('{d: 8'h31, p: 1'b1, t: n0 + 2});
    idle(16);
    drain(16);
    put(16, 8'h33);
    n0 = cyc + 1;
    q16.push_back('{d: 8'h33, p: 1'b0, t: n0 + 2});
    idle(16);
    drain(16);
`endif

    chk("final q16", q16.size(), 0);
    chk("final q4", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
